instr_fetch_buffer: RTL

Parametrised in-order fetch queue between the instruction cache and the decoders in the front-end. It is the successor of the fixed two-lane loader. It accepts up to FETCH_WIDTH fetched instructions per cycle, buffers them in a circular queue of DEPTH entries, and presents up to ISSUE_WIDTH instructions per cycle to the decoders. It decouples cache hit patterns from decoder stalls and supports flush on redirect.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/global_signals_if.sv | 7 +
 rtl/fetch_ring.sv | 70 +++++++
 rtl/instr_fetch_buffer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and hit-prefix helper for the instruction fetch buffer
package fetch_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int FETCH_WIDTH_DEF = 2;
    localparam int ISSUE_WIDTH_DEF = 2;
    localparam int DEPTH_DEF       = 8;
    localparam int ILEN            = 32;
    localparam int MAX_LANES       = 16;

    // Number of consecutive ones starting at bit 0; callers zero-extend narrower hit vectors.
    function automatic int unsigned prefix_len(input logic [MAX_LANES-1:0] hit);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            run = run & hit[i];
            if (run) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/global_signals_if.sv
// rtl/global_signals_if.sv - clock and reset bundle shared by front-end blocks
interface global_signals_if;
    logic clk;
    logic reset;

    modport sink (input clk, input reset);
endinterface

// File: rtl/fetch_ring.sv
// rtl/fetch_ring.sv - circular instruction store with multi-lane write and read ports
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int PW          = $clog2(DEPTH),
    parameter int CW          = $clog2(DEPTH+1)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  flush_i,
    input  logic [CW-1:0]                         enq_n_i,
    input  logic [FETCH_WIDTH-1:0][XLEN-1:0]      wr_addr_i,
    input  logic [FETCH_WIDTH-1:0][ILEN-1:0]      wr_instr_i,
    input  logic [CW-1:0]                         deq_n_i,
    output logic [ISSUE_WIDTH-1:0][XLEN-1:0]      rd_addr_o,
    output logic [ISSUE_WIDTH-1:0][ILEN-1:0]      rd_instr_o,
    output logic [CW-1:0]                         count_o
);

    logic [XLEN-1:0] addr_mem_q  [DEPTH];
    logic [ILEN-1:0] instr_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(enq_n_i);
        rd_ptr_d = rd_ptr_q + PW'(deq_n_i);
        count_d  = count_q + enq_n_i - deq_n_i;
    end

    always_ff @(posedge clk_i) begin
        if (!(reset_i || flush_i)) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (CW'(k) < enq_n_i) begin
                    addr_mem_q[wr_ptr_q + PW'(k)]  <= wr_addr_i[k];
                    instr_mem_q[wr_ptr_q + PW'(k)] <= wr_instr_i[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Read ports always show the oldest entries; the consumer decides how many it takes.
    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            rd_addr_o[k]  = addr_mem_q[rd_ptr_q + PW'(k)];
            rd_instr_o[k] = instr_mem_q[rd_ptr_q + PW'(k)];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - fetch queue top: accept, stall, presentation registers; FETCH_BUFFER_BYPASS_EN enables empty-queue bypass
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    global_signals_if.sink                       gsi,
    input  logic                                 flush,
    input  logic [FETCH_WIDTH-1:0][XLEN-1:0]     address_in,
    input  logic [FETCH_WIDTH-1:0][31:0]         instrs_in,
    input  logic [FETCH_WIDTH-1:0]               hit,
    input  logic                                 stop,
    output logic [ISSUE_WIDTH-1:0][XLEN-1:0]     address_out,
    output logic [ISSUE_WIDTH-1:0][31:0]         instrs_out,
    output logic [ISSUE_WIDTH-1:0]               valid_out,
    output logic                                 stall_fetch,
    output logic [$clog2(DEPTH+1)-1:0]           fullness
);

    localparam int CW = $clog2(DEPTH+1);

    logic clk;
    logic reset;
    assign clk   = gsi.clk;
    assign reset = gsi.reset;

    logic [CW-1:0]                    count;
    logic [CW-1:0]                    plen;
    logic [CW-1:0]                    accepted_n;
    logic [CW-1:0]                    enq_n;
    logic [CW-1:0]                    deq_n;
    logic [MAX_LANES-1:0]             hit_ext;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] wr_addr;
    logic [FETCH_WIDTH-1:0][ILEN-1:0] wr_instr;
    logic [ISSUE_WIDTH-1:0][XLEN-1:0] rd_addr;
    logic [ISSUE_WIDTH-1:0][ILEN-1:0] rd_instr;

    logic [ISSUE_WIDTH-1:0][XLEN-1:0] addr_q,  addr_d;
    logic [ISSUE_WIDTH-1:0][ILEN-1:0] instr_q, instr_d;
    logic [ISSUE_WIDTH-1:0]           valid_q, valid_d;

    assign hit_ext = MAX_LANES'(hit);
    assign plen    = CW'(prefix_len(hit_ext));

    // Stall depends only on registered occupancy so hit/stop never reach it combinationally.
    assign stall_fetch = (CW'(DEPTH) - count) < CW'(FETCH_WIDTH);
    assign fullness    = count;

    assign accepted_n = (stall_fetch || flush || reset) ? '0 : plen;
    assign deq_n      = stop ? '0 :
                        ((count > CW'(ISSUE_WIDTH)) ? CW'(ISSUE_WIDTH) : count);

`ifdef FETCH_BUFFER_BYPASS_EN
    localparam int BYP_LANES = (FETCH_WIDTH < ISSUE_WIDTH) ? FETCH_WIDTH : ISSUE_WIDTH;

    logic          bypass_en;
    logic [CW-1:0] byp_n;

    assign bypass_en = (count == '0) && !stop && !flush;
    assign byp_n     = !bypass_en ? '0 :
                       ((accepted_n > CW'(BYP_LANES)) ? CW'(BYP_LANES) : accepted_n);
    assign enq_n     = accepted_n - byp_n;

    // Lanes that went straight to the outputs are skipped; the remainder is packed into the ring.
    always_comb begin
        wr_addr  = '0;
        wr_instr = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (j == k + int'(byp_n)) begin
                    wr_addr[k]  = address_in[j];
                    wr_instr[k] = instrs_in[j];
                end
            end
        end
    end
`else
    assign enq_n    = accepted_n;
    assign wr_addr  = address_in;
    assign wr_instr = instrs_in;
`endif

    fetch_ring #(
        .XLEN        (XLEN),
        .FETCH_WIDTH (FETCH_WIDTH),
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .DEPTH       (DEPTH)
    ) u_ring (
        .clk_i      (clk),
        .reset_i    (reset),
        .flush_i    (flush),
        .enq_n_i    (enq_n),
        .wr_addr_i  (wr_addr),
        .wr_instr_i (wr_instr),
        .deq_n_i    (deq_n),
        .rd_addr_o  (rd_addr),
        .rd_instr_o (rd_instr),
        .count_o    (count)
    );

    always_comb begin
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (!stop) begin
            addr_d  = rd_addr;
            instr_d = rd_instr;
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                valid_d[k] = CW'(k) < deq_n;
            end
        end
`ifdef FETCH_BUFFER_BYPASS_EN
        if (bypass_en) begin
            for (int k = 0; k < BYP_LANES; k++) begin
                addr_d[k]  = address_in[k];
                instr_d[k] = instrs_in[k];
            end
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                valid_d[k] = CW'(k) < byp_n;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign address_out = addr_q;
    assign instrs_out  = instr_q;
    assign valid_out   = valid_q;

endmodule
